// File: rtl/gpio_pad_pkg.sv
// Shared types and constants for the GPIO pad controller: irq mode encodings,
// pad control bundles and the config-to-pad drive mapping.
package gpio_pad_pkg;

  localparam int FILT_W_DEF = 4;

  localparam logic [1:0] IRQ_MODE_RISE = 2'b00;
  localparam logic [1:0] IRQ_MODE_FALL = 2'b01;
  localparam logic [1:0] IRQ_MODE_BOTH = 2'b10;
  localparam logic [1:0] IRQ_MODE_LVL  = 2'b11;

  typedef struct packed {
    logic ie;
    logic oe;
    logic out;
    logic pue;
    logic pde;
    logic od;
    logic os;
    logic cs;
    logic dr;
    logic sr;
  } pad_cfg_t;

  typedef struct packed {
    logic ie;
    logic oval;
    logic oe;
    logic pue;
    logic pde;
    logic os;
    logic od;
    logic cs;
    logic dr;
    logic sr;
  } pad_ctl_t;

  // Open-drain only ever pulls low: drive enable tracks a low output value.
  // A pull-up/pull-down conflict resolves to pull-up.
  function automatic pad_ctl_t pad_drive(input pad_cfg_t c);
    pad_ctl_t p;
    p      = '0;
    p.ie   = c.ie;
    p.oval = c.od ? 1'b0 : c.out;
    p.oe   = c.od ? (c.oe & ~c.out) : c.oe;
    p.od   = c.od;
    p.pue  = c.pue;
    p.pde  = c.pde & ~c.pue;
    p.os   = c.os;
    p.cs   = c.cs;
    p.dr   = c.dr;
    p.sr   = c.sr;
    return p;
  endfunction

endpackage

// File: rtl/gnrl_pad_filter.sv
// Two-flop synchroniser followed by a glitch filter on the pad input.
// Filter logic only exists when GPIO_PAD_FILTER_EN is defined; otherwise
// the synchronised value is registered once and thr is ignored.
module gnrl_pad_filter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         din,
  input  logic [W-1:0] thr,
  output logic         dout
);

  logic [1:0] sync_q;
  logic       s;
  logic       dout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], din};
  end

  assign s = sync_q[1];

`ifdef GPIO_PAD_FILTER_EN
  logic [W-1:0] cnt;

  // >= rather than == so a threshold lowered mid-count still fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      dout_q <= 1'b0;
    end else if (s == dout_q) begin
      cnt    <= '0;
    end else if (cnt >= thr) begin
      cnt    <= '0;
      dout_q <= ~dout_q;
    end else begin
      cnt    <= cnt + 1'b1;
    end
  end
`else
  logic unused_thr;
  assign unused_thr = ^thr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout_q <= 1'b0;
    else        dout_q <= s;
  end
`endif

  assign dout = dout_q;

endmodule

// File: rtl/gpio_pad_ctrl.sv
// Controller side of one bidirectional GPIO pad: registered pad drive,
// filtered input, edge/level detect and sticky interrupt. Glitch filter
// is compiled in with GPIO_PAD_FILTER_EN.
module gpio_pad_ctrl
  import gpio_pad_pkg::*;
#(
  parameter int FILT_W  = FILT_W_DEF,
  parameter bit RST_PUE = 1'b0,
  parameter bit RST_PDE = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_ie,
  input  logic              cfg_oe,
  input  logic              cfg_out,
  input  logic              cfg_pue,
  input  logic              cfg_pde,
  input  logic              cfg_od,
  input  logic              cfg_os,
  input  logic              cfg_cs,
  input  logic              cfg_dr,
  input  logic              cfg_sr,
  input  logic [FILT_W-1:0] cfg_filt_thr,
  input  logic              cfg_irq_en,
  input  logic [1:0]        cfg_irq_mode,
  input  logic              irq_clr,
  output logic              pad_o_ie,
  output logic              pad_o_oval,
  output logic              pad_o_oe,
  output logic              pad_o_pue,
  output logic              pad_o_pde,
  output logic              pad_o_os,
  output logic              pad_o_od,
  output logic              pad_o_cs,
  output logic              pad_o_dr,
  output logic              pad_o_sr,
  input  logic              pad_i_ival,
  output logic              in_val,
  output logic              irq_pend,
  output logic              irq
);

  pad_cfg_t cfg;
  pad_ctl_t ctl_q;

  assign cfg = '{ie: cfg_ie, oe: cfg_oe, out: cfg_out, pue: cfg_pue,
                 pde: cfg_pde, od: cfg_od, os: cfg_os, cs: cfg_cs,
                 dr: cfg_dr, sr: cfg_sr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q     <= '0;
      ctl_q.pue <= RST_PUE;
      ctl_q.pde <= RST_PDE;
    end else begin
      ctl_q     <= pad_drive(cfg);
    end
  end

  assign pad_o_ie   = ctl_q.ie;
  assign pad_o_oval = ctl_q.oval;
  assign pad_o_oe   = ctl_q.oe;
  assign pad_o_pue  = ctl_q.pue;
  assign pad_o_pde  = ctl_q.pde;
  assign pad_o_os   = ctl_q.os;
  assign pad_o_od   = ctl_q.od;
  assign pad_o_cs   = ctl_q.cs;
  assign pad_o_dr   = ctl_q.dr;
  assign pad_o_sr   = ctl_q.sr;

  logic in_val_q;
  logic in_val_d;

  gnrl_pad_filter #(.W(FILT_W)) u_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (pad_i_ival),
    .thr   (cfg_filt_thr),
    .dout  (in_val_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_val_d <= 1'b0;
    else        in_val_d <= in_val_q;
  end

  logic rise, fall, set;

  assign rise = in_val_q & ~in_val_d;
  assign fall = ~in_val_q & in_val_d;

  always_comb begin
    set = 1'b0;
    case (cfg_irq_mode)
      IRQ_MODE_RISE: set = rise;
      IRQ_MODE_FALL: set = fall;
      IRQ_MODE_BOTH: set = rise | fall;
      IRQ_MODE_LVL:  set = in_val_q;
      default:       set = 1'b0;
    endcase
  end

  // Set beats clear; in level mode this keeps the flag up while in_val is high.
  logic pend_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       pend_q <= 1'b0;
    else if (set)     pend_q <= 1'b1;
    else if (irq_clr) pend_q <= 1'b0;
  end

  assign in_val   = in_val_q;
  assign irq_pend = pend_q;
  assign irq      = pend_q & cfg_irq_en;

endmodule
